// File: rtl/booth_control.sv
// Booth radix-2 multiplier sequencer: steps LOAD_M, LOAD_Q, then CHECK/ARITH/SHIFT per bit.
// Outputs decode from state alone. Start is only honoured in IDLE, so requests during a run are dropped.
module booth_control (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mcand,
  input  logic [15:0] mplier,
  input  logic        q0,
  input  logic        qm1,
  input  logic        eqz,
  output logic [15:0] data_out,
  output logic        ldA,
  output logic        clrA,
  output logic        sftA,
  output logic        ldQ,
  output logic        clrQ,
  output logic        sftQ,
  output logic        ldM,
  output logic        clrff,
  output logic        addsub,
  output logic        decr,
  output logic        ldcnt,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_Q = 3'd2,
    CHECK  = 3'd3,
    ARITH  = 3'd4,
    SHIFT  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mc_r, mp_r;
  logic        addsub_q, addsub_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mc_r     <= 16'h0000;
      mp_r     <= 16'h0000;
      addsub_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addsub_q <= addsub_d;
      if (state_q == IDLE && start) begin
        mc_r <= mcand;
        mp_r <= mplier;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addsub_d = addsub_q;
    data_out = 16'h0000;
    ldA      = 1'b0;
    clrA     = 1'b0;
    sftA     = 1'b0;
    ldQ      = 1'b0;
    clrQ     = 1'b0;
    sftQ     = 1'b0;
    ldM      = 1'b0;
    clrff    = 1'b0;
    addsub   = 1'b0;
    decr     = 1'b0;
    ldcnt    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_M;
      end
      LOAD_M: begin
        busy     = 1'b1;
        data_out = mc_r;
        ldM      = 1'b1;
        clrA     = 1'b1;
        clrff    = 1'b1;
        ldcnt    = 1'b1;
        state_d  = LOAD_Q;
      end
      LOAD_Q: begin
        busy     = 1'b1;
        data_out = mp_r;
        ldQ      = 1'b1;
        state_d  = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        // Count exhaustion wins over the Booth bit pair.
        if (eqz) begin
          state_d = DONE;
        end else begin
          case ({q0, qm1})
            2'b01:   begin addsub_d = 1'b1; state_d = ARITH; end
            2'b10:   begin addsub_d = 1'b0; state_d = ARITH; end
            default: state_d = SHIFT;
          endcase
        end
      end
      ARITH: begin
        busy    = 1'b1;
        ldA     = 1'b1;
        addsub  = addsub_q;
        state_d = SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        sftA    = 1'b1;
        sftQ    = 1'b1;
        decr    = 1'b1;
        state_d = CHECK;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_control.sv
// Directed bench for booth_control with a small datapath model feeding q0/qm1/eqz and a result scoreboard.
module tb_booth_control;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] mcand, mplier;
  logic        q0, qm1, eqz;
  logic [15:0] data_out;
  logic        ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, addsub, decr, ldcnt, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int n_arith = 0, n_shift = 0, n_done = 0;
  logic [15:0] exp_mc = 16'h0000, exp_mp = 16'h0000;

  typedef struct {
    int lat;
    int arith;
    int shifts;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  booth_control dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .q0(q0), .qm1(qm1), .eqz(eqz), .data_out(data_out),
    .ldA(ldA), .clrA(clrA), .sftA(sftA), .ldQ(ldQ), .clrQ(clrQ), .sftQ(sftQ),
    .ldM(ldM), .clrff(clrff), .addsub(addsub), .decr(decr), .ldcnt(ldcnt),
    .busy(busy), .done(done)
  );

  // Datapath stand-in: iteration counter, Q register and Q(-1).
  logic [4:0]  cnt_m = 5'd0;
  logic [15:0] q_m   = 16'h0000;
  logic        qm1_m = 1'b0;
  always @(posedge clk) begin
    if (ldcnt) cnt_m <= 5'd16;
    else if (decr) cnt_m <= cnt_m - 5'd1;
    if (ldQ) q_m <= data_out;
    else if (sftQ) q_m <= {1'b0, q_m[15:1]};
    if (clrff) qm1_m <= 1'b0;
    else if (sftQ) qm1_m <= q_m[0];
  end
  assign q0  = q_m[0];
  assign qm1 = qm1_m;
  assign eqz = (cnt_m == 5'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle protocol checks.
  always @(negedge clk) begin
    check("pair_ldA", {31'd0, ldA & (clrA | sftA)}, 32'd0);
    check("shift_grp", {29'd0, sftA, sftQ, decr}, sftA ? 32'd7 : 32'd0);
    check("load_grp", {28'd0, ldM, clrA, clrff, ldcnt}, ldM ? 32'd15 : 32'd0);
    if (!ldM && !ldQ) check("dout_zero", {16'd0, data_out}, 32'd0);
    if (ldM) check("dout_mc", {16'd0, data_out}, {16'd0, exp_mc});
    if (ldQ) check("dout_mp", {16'd0, data_out}, {16'd0, exp_mp});
    if (ldA) begin
      check("arith_bits", {31'd0, q0 ^ qm1}, 32'd1);
      check("addsub", {31'd0, addsub}, {31'd0, (!q0 && qm1)});
      n_arith++;
    end
    if (!ldA) check("addsub_off", {31'd0, addsub}, 32'd0);
    if (sftA) n_shift++;
    if (done) n_done++;
    if (!busy)
      check("idle_ctrl", {20'd0, ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, addsub, decr, ldcnt, done}, 32'd0);
  end

  task automatic run_op(input logic [15:0] mc, input logic [15:0] mp,
                        input int exp_lat, input int exp_ar, input bit stray);
    int a0, s0, d0, lat;
    exp_t e;
    sb.push_back('{exp_lat, exp_ar, 16});
    exp_mc = mc;
    exp_mp = mp;
    a0 = n_arith; s0 = n_shift; d0 = n_done;
    mcand = mc; mplier = mp; start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (stray && (k == 1 || k == 2)) begin
        start = 1'b1; mcand = ~mc; mplier = ~mp;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
    if (stray) begin
      start = 1'b1; mcand = 16'h1234; mplier = 16'h5678;
    end
    @(negedge clk);
    check("idle_after_done", {31'd0, busy}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("arith_cnt", n_arith - a0, e.arith);
    check("shift_cnt", n_shift - s0, e.shifts);
    check("done_cnt", n_done - d0, 32'd1);
  endtask

  initial begin
    int sh;
    rst = 1'b1; start = 1'b0; mcand = 16'h0000; mplier = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_dout", {16'd0, data_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h0003, 16'h0000, 36, 0, 1'b0);
    run_op(16'h0003, 16'h0001, 38, 2, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 37, 1, 1'b0);
    run_op(16'h8001, 16'h8000, 37, 1, 1'b0);
    run_op(16'h00A5, 16'h5555, 52, 16, 1'b0);
    run_op(16'h5A5A, 16'hAAAA, 51, 15, 1'b0);
    run_op(16'h0C0C, 16'h0001, 38, 2, 1'b1);

    // Reset in the third SHIFT of a run.
    exp_mc = 16'h0003; exp_mp = 16'h0000;
    mcand = 16'h0003; mplier = 16'h0000; start = 1'b1;
    sh = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (sftA) sh++;
      if (sh == 3) break;
    end
    check("third_shift_seen", sh, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ctrl", {19'd0, ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, addsub, decr, ldcnt, busy, done}, 32'd0);
    check("rst_mid_dout", {16'd0, data_out}, 32'd0);
    start = 1'b1; mcand = 16'hBEEF; mplier = 16'hFFFF;
    @(negedge clk);
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    run_op(16'h0003, 16'h0000, 36, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
